// File: rtl/audio_tone_analyzer.sv
// Tone analyzer for a signed 16-bit audio sample stream.
// It measures the tone period from rising zero crossings and the
// peak-to-peak amplitude over each period. It also reports lock and
// loss-of-signal status.
//
// Optional feature: define DC_OFFSET_EN to add the dc_offset output,
// which is the midpoint of max and min over each measured period.
//
// Ports:
//   clk_audio     audio sample clock, rising edge
//   reset_n       asynchronous active-low reset
//   sample_valid  qualifies sample; may be gapped
//   sample        signed 16-bit audio sample
//   period        last measured period, in valid samples
//   peak_to_peak  max-min over the last period (unsigned, 17 bits)
//   meas_valid    one-cycle pulse when period/peak_to_peak update
//   locked        stable tone detected
//   no_signal     no crossing within MAX_PERIOD valid samples
//   dc_offset     signed midpoint of the last period (DC_OFFSET_EN only)
module audio_tone_analyzer #(
  parameter int unsigned HYST       = 256,
  parameter int unsigned MAX_PERIOD = 4096,
  parameter int unsigned LOCK_TOL   = 1,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned PW         = $clog2(MAX_PERIOD + 1)
) (
  input  logic                 clk_audio,
  input  logic                 reset_n,
  input  logic                 sample_valid,
  input  logic signed [15:0]   sample,
  output logic [PW-1:0]        period,
  output logic [16:0]          peak_to_peak,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 no_signal
`ifdef DC_OFFSET_EN
  ,
  output logic signed [15:0]   dc_offset
`endif
);

  localparam int unsigned MW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned PW1 = PW + 1;
  localparam logic signed [16:0] NEG_HYST = -$signed(17'(HYST));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t              state;
  logic [PW-1:0]       cnt;
  logic                armed;
  logic [MW-1:0]       match_cnt;
  logic signed [15:0]  run_max;
  logic signed [15:0]  run_min;

  logic signed [16:0]  sample_ext;
  logic                arm_c;
  logic                cross_c;
  logic                timeout_c;
  logic signed [15:0]  cur_max_c;
  logic signed [15:0]  cur_min_c;
  logic signed [16:0]  max_ext;
  logic signed [16:0]  min_ext;
  logic [16:0]         p2p_c;
  logic [PW-1:0]       new_period_c;
  logic signed [PW:0]  diff_c;
  logic [PW:0]         abs_diff_c;
  logic                match_c;

  // Crossing / arming / timeout detection on the current sample
  assign sample_ext = {sample[15], sample};
  assign arm_c      = (sample_ext < NEG_HYST);
  assign cross_c    = armed && !sample[15];
  assign timeout_c  = (cnt == PW'(MAX_PERIOD - 1));

  // Running extremes including the current sample
  assign cur_max_c = (sample > run_max) ? sample : run_max;
  assign cur_min_c = (sample < run_min) ? sample : run_min;
  assign max_ext   = {cur_max_c[15], cur_max_c};
  assign min_ext   = {cur_min_c[15], cur_min_c};
  assign p2p_c     = $unsigned(max_ext - min_ext);

  // Period of the crossing sample and its distance to the previous one
  assign new_period_c = cnt + PW'(1);
  assign diff_c       = $signed({1'b0, new_period_c}) - $signed({1'b0, period});
  assign abs_diff_c   = diff_c[PW] ? $unsigned(-diff_c) : $unsigned(diff_c);
  assign match_c      = (abs_diff_c <= PW1'(LOCK_TOL));

`ifdef DC_OFFSET_EN
  logic signed [16:0] dc_sum_c;
  // Bits [16:1] are the arithmetic shift right by one, truncated to 16 bits
  assign dc_sum_c = max_ext + min_ext;
`endif

  // State machine, counters and registered outputs
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      armed        <= 1'b0;
      match_cnt    <= '0;
      run_max      <= '0;
      run_min      <= '0;
      period       <= '0;
      peak_to_peak <= '0;
      meas_valid   <= 1'b0;
      locked       <= 1'b0;
      no_signal    <= 1'b1;
`ifdef DC_OFFSET_EN
      dc_offset    <= '0;
`endif
    end else begin
      meas_valid <= 1'b0;
      if (sample_valid) begin
        if (arm_c) begin
          armed <= 1'b1;
        end
        if (cross_c) begin
          armed   <= 1'b0;
          cnt     <= '0;
          run_max <= sample;
          run_min <= sample;
          if (state != IDLE) begin
            period       <= new_period_c;
            peak_to_peak <= p2p_c;
            meas_valid   <= 1'b1;
`ifdef DC_OFFSET_EN
            dc_offset    <= dc_sum_c[16:1];
`endif
          end
          case (state)
            IDLE: begin
              // First crossing only starts the measurement window
              no_signal <= 1'b0;
              state     <= MEASURE;
            end
            MEASURE: begin
              if (match_c) begin
                match_cnt <= match_cnt + MW'(1);
                if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end
            LOCKED: begin
              if (!match_c) begin
                locked    <= 1'b0;
                match_cnt <= '0;
                state     <= MEASURE;
              end
            end
            default: state <= IDLE;
          endcase
        end else begin
          run_max <= cur_max_c;
          run_min <= cur_min_c;
          if (timeout_c) begin
            // Loss of signal: keep the last measurement and restart
            state     <= IDLE;
            no_signal <= 1'b1;
            locked    <= 1'b0;
            cnt       <= '0;
            match_cnt <= '0;
            armed     <= 1'b0;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_tone_analyzer.sv
// Directed bench for audio_tone_analyzer: table of tone segments plus
// hand sequences for timeout, async reset and hysteresis.
module tb_audio_tone_analyzer;

  localparam int unsigned PW = 13;

  logic               clk_audio = 1'b0;
  logic               reset_n;
  logic               sample_valid;
  logic signed [15:0] sample;
  logic [PW-1:0]      period;
  logic [16:0]        peak_to_peak;
  logic               meas_valid;
  logic               locked;
  logic               no_signal;
`ifdef DC_OFFSET_EN
  logic signed [15:0] dc_offset;
`endif

  audio_tone_analyzer dut (
    .clk_audio    (clk_audio),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .period       (period),
    .peak_to_peak (peak_to_peak),
    .meas_valid   (meas_valid),
    .locked       (locked),
    .no_signal    (no_signal)
`ifdef DC_OFFSET_EN
    ,
    .dc_offset    (dc_offset)
`endif
  );

  always #5 clk_audio = ~clk_audio;

  typedef struct {
    int n;        // samples per tone period
    int amp;
    int off;
    int gap;      // invalid cycles after each valid sample
    int start;    // first phase index
    int count;    // valid samples to send
    int e_meas;   // expected meas_valid pulses
    int e_period;
    int e_p2p;
    int e_locked;
    int e_nosig;
    int e_rise;   // measurement number at which locked rose (0 = none)
    int e_fall;   // measurement number at which locked fell (0 = none)
  } row_t;

  row_t rows[6];

  int errors = 0;
  int checks = 0;
  int meas_n, rise_at, fall_at, dbl_n;
  logic prev_lk, prev_mv;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic logic signed [15:0] tone(input int n, input int idx, input int amp, input int off);
    real x;
    int  v;
    x = amp * $sin(2.0 * 3.14159265358979 * real'(idx % n) / real'(n));
    v = $rtoi($floor(x + 0.5)) + off;
    return 16'(v);
  endfunction

  task automatic track_reset();
    meas_n  = 0;
    rise_at = 0;
    fall_at = 0;
    dbl_n   = 0;
    prev_lk = locked;
    prev_mv = meas_valid;
  endtask

  // One clock: drive at negedge, observe 1 time unit after posedge
  task automatic step(input logic v, input logic signed [15:0] s);
    @(negedge clk_audio);
    sample_valid = v;
    sample       = s;
    @(posedge clk_audio);
    #1;
    if (meas_valid) begin
      meas_n++;
      if (prev_mv) dbl_n++;
    end
    if (locked && !prev_lk) rise_at = meas_n;
    if (!locked && prev_lk) fall_at = meas_n;
    prev_lk = locked;
    prev_mv = meas_valid;
  endtask

  task automatic run_row(input int k);
    row_t r;
    r = rows[k];
    track_reset();
    for (int c = 0; c < r.count; c++) begin
      step(1'b1, tone(r.n, r.start + c, r.amp, r.off));
      for (int g = 0; g < r.gap; g++) step(1'b0, -16'sd30000);
    end
    step(1'b0, 16'sd0);
    chk($sformatf("row%0d meas_count", k), meas_n, r.e_meas);
    chk($sformatf("row%0d period", k), int'(period), r.e_period);
    chk($sformatf("row%0d peak_to_peak", k), int'(peak_to_peak), r.e_p2p);
    chk($sformatf("row%0d locked", k), int'(locked), r.e_locked);
    chk($sformatf("row%0d no_signal", k), int'(no_signal), r.e_nosig);
    chk($sformatf("row%0d lock_rise_at", k), rise_at, r.e_rise);
    chk($sformatf("row%0d lock_fall_at", k), fall_at, r.e_fall);
    chk($sformatf("row%0d meas_valid_width", k), dbl_n, 0);
  endtask

  initial begin
    //           n    amp   off gap st cnt  meas per  p2p   lk ns rise fall
    rows[0] = '{128, 32767, 0, 0, 0, 769, 5, 128, 65534, 1, 0, 5, 0};
    rows[1] = '{128, 32767, 0, 2, 1, 384, 3, 128, 65534, 1, 0, 0, 0};
    rows[2] = '{ 64, 32767, 0, 0, 1, 384, 6,  64, 65534, 1, 0, 5, 1};
    rows[3] = '{128, 32767, 0, 0, 1, 768, 6, 128, 65534, 1, 0, 5, 1};
    rows[4] = '{128, 32767, 0, 0, 1, 128, 0, 128, 65534, 0, 0, 0, 0};
    rows[5] = '{128, 32767, 0, 0, 1, 128, 1, 128, 65534, 0, 0, 0, 0};

    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    repeat (3) @(posedge clk_audio);
    #1;
    chk("reset period", int'(period), 0);
    chk("reset peak_to_peak", int'(peak_to_peak), 0);
    chk("reset meas_valid", int'(meas_valid), 0);
    chk("reset locked", int'(locked), 0);
    chk("reset no_signal", int'(no_signal), 1);
    @(negedge clk_audio);
    reset_n = 1'b1;

    // Acquire, gapped stream, retune to 64 and back to 128
    for (int k = 0; k < 4; k++) run_row(k);

    // Constant zero then sub-hysteresis noise until the timeout fires
    track_reset();
    for (int k = 1; k <= 4096; k++) begin
      step(1'b1, (k <= 2000) ? 16'sd0 : ((k % 2 != 0) ? 16'sd100 : -16'sd100));
      if (k == 4095) begin
        chk("timeout-1 no_signal", int'(no_signal), 0);
        chk("timeout-1 locked", int'(locked), 1);
      end
      if (k == 4096) begin
        chk("timeout no_signal", int'(no_signal), 1);
        chk("timeout locked", int'(locked), 0);
        chk("timeout period held", int'(period), 128);
        chk("timeout p2p held", int'(peak_to_peak), 65534);
      end
    end
    chk("timeout meas_count", meas_n, 0);

    // Reacquire: first crossing from IDLE gives no measurement
    for (int k = 4; k < 6; k++) run_row(k);

    // Asynchronous reset mid-stream, away from any clock edge
    @(negedge clk_audio);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset period", int'(period), 0);
    chk("async reset peak_to_peak", int'(peak_to_peak), 0);
    chk("async reset meas_valid", int'(meas_valid), 0);
    chk("async reset locked", int'(locked), 0);
    chk("async reset no_signal", int'(no_signal), 1);
    @(negedge clk_audio);
    reset_n = 1'b1;

    // Exactly -HYST must not arm; one below must
    track_reset();
    step(1'b1, -16'sd256);
    step(1'b1, 16'sd0);
    step(1'b1, 16'sd50);
    chk("hyst -256 no arm", int'(no_signal), 1);
    step(1'b1, -16'sd257);
    step(1'b1, 16'sd0);
    chk("hyst -257 arms", int'(no_signal), 0);
    chk("hyst first crossing no meas", meas_n, 0);

`ifdef DC_OFFSET_EN
    @(negedge clk_audio);
    reset_n = 1'b0;
    @(negedge clk_audio);
    reset_n = 1'b1;
    track_reset();
    for (int c = 0; c < 384; c++) step(1'b1, tone(128, c, 20000, 1000));
    step(1'b0, 16'sd0);
    chk("dc meas_count", meas_n, 2);
    chk("dc period", int'(period), 128);
    chk_tol("dc peak_to_peak", int'(peak_to_peak), 40000, 2);
    chk_tol("dc offset", int'(dc_offset), 1000, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
